i2c_target_regs: RTL

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

---
 rtl/i2c_target_regs.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target (slave) with an NREGS x 8 register file.
//   The master writes a register pointer, then data bytes that land in the
//   register file (auto-incrementing); reads return bytes from the pointer on.
// Ports:
//   clk50    system clock
//   rst      synchronous reset, active high
//   scl_i    raw SCL pin (asynchronous)
//   sda_i    raw SDA pin (asynchronous)
//   sda_oe   1 = pull SDA low, 0 = release
//   wr_valid one-cycle pulse per data byte written by the master
//   wr_addr  register index of that write
//   wr_data  byte written
//   busy     high from an addressed START until the next STOP or START
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter int         NREGS    = 16
) (
  input  logic       clk50,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);
  localparam int PW = $clog2(NREGS);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK
  } state_t;

  // Pin conditioning: 2-flop synchronizer, then the filtered level only
  // follows once three consecutive synced samples agree.
  logic [1:0] scl_s, sda_s;
  logic [2:0] scl_h, sda_h;
  logic       scl_f, sda_f, scl_q, sda_q;

  always_ff @(posedge clk50) begin
    if (rst) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_h <= 3'b111;
      sda_h <= 3'b111;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], scl_i};
      sda_s <= {sda_s[0], sda_i};
      scl_h <= {scl_h[1:0], scl_s[1]};
      sda_h <= {sda_h[1:0], sda_s[1]};
      if (scl_h == 3'b111)      scl_f <= 1'b1;
      else if (scl_h == 3'b000) scl_f <= 1'b0;
      if (sda_h == 3'b111)      sda_f <= 1'b1;
      else if (sda_h == 3'b000) sda_f <= 1'b0;
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_c, stop_c;
  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;

  state_t          state, state_n;
  logic [3:0]      bcnt, bcnt_n;
  logic [7:0]      sh, sh_n;
  logic [PW-1:0]   ptr, ptr_n, ptr_inc;
  logic            rw, rw_n;
  logic            sda_oe_n, busy_n, wr_valid_n;
  logic [7:0]      wr_addr_n, wr_data_n;
  logic            reg_we;
  logic [7:0]      regs [NREGS];
  logic [7:0]      byte_in, rd_cur, rd_nxt;

  assign byte_in = {sh[6:0], sda_f};
  assign ptr_inc = ptr + PW'(1);      // natural wrap = modulo NREGS
  assign rd_cur  = regs[ptr];
  assign rd_nxt  = regs[ptr_inc];

  always_comb begin
    state_n    = state;
    bcnt_n     = bcnt;
    sh_n       = sh;
    ptr_n      = ptr;
    rw_n       = rw;
    sda_oe_n   = sda_oe;
    busy_n     = busy;
    wr_valid_n = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    reg_we     = 1'b0;
    if (stop_c) begin
      state_n  = IDLE;
      bcnt_n   = '0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_c) begin
      state_n  = ADDR;
      bcnt_n   = '0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR:
          if (scl_rise) begin
            sh_n   = byte_in;
            bcnt_n = bcnt + 4'd1;
            if (bcnt == 4'd7) begin
              bcnt_n = '0;
              if (byte_in[7:1] == DEV_ADDR) begin
                state_n = ADDR_ACK;
                busy_n  = 1'b1;
                rw_n    = byte_in[0];
              end else begin
                state_n = IDLE;
              end
            end
          end
        // ACK states use sda_oe itself as the phase flag: first SCL fall
        // pulls SDA low, the following fall releases it and moves on.
        ADDR_ACK:
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else if (rw) begin
              state_n  = RDATA;
              sh_n     = rd_cur;
              sda_oe_n = ~rd_cur[7];
              bcnt_n   = '0;
            end else begin
              state_n  = REG;
              sda_oe_n = 1'b0;
            end
          end
        REG:
          if (scl_rise) begin
            sh_n   = byte_in;
            bcnt_n = bcnt + 4'd1;
            if (bcnt == 4'd7) begin
              bcnt_n  = '0;
              ptr_n   = byte_in[PW-1:0];
              state_n = REG_ACK;
            end
          end
        REG_ACK:
          if (scl_fall) begin
            if (!sda_oe) sda_oe_n = 1'b1;
            else begin
              sda_oe_n = 1'b0;
              state_n  = WDATA;
            end
          end
        WDATA:
          if (scl_rise) begin
            sh_n   = byte_in;
            bcnt_n = bcnt + 4'd1;
            if (bcnt == 4'd7) begin
              bcnt_n     = '0;
              reg_we     = 1'b1;
              wr_valid_n = 1'b1;
              wr_addr_n  = 8'(ptr);
              wr_data_n  = byte_in;
              state_n    = WDATA_ACK;
            end
          end
        WDATA_ACK:
          if (scl_fall) begin
            if (!sda_oe) sda_oe_n = 1'b1;
            else begin
              sda_oe_n = 1'b0;
              ptr_n    = ptr_inc;
              state_n  = WDATA;
            end
          end
        // sh[7] always holds the bit to present after the next SCL fall.
        RDATA: begin
          if (scl_rise) begin
            bcnt_n = bcnt + 4'd1;
            sh_n   = {sh[6:0], 1'b0};
          end
          if (scl_fall) begin
            if (bcnt == 4'd8) begin
              sda_oe_n = 1'b0;
              bcnt_n   = '0;
              state_n  = RDATA_MACK;
            end else begin
              sda_oe_n = ~sh[7];
            end
          end
        end
        // bcnt=1 marks "master ACKed, continue on the next fall".
        RDATA_MACK: begin
          if (scl_rise) begin
            if (sda_f) state_n = IDLE;   // NACK: busy stays up until STOP
            else       bcnt_n  = 4'd1;
          end
          if (scl_fall && bcnt == 4'd1) begin
            ptr_n    = ptr_inc;
            sh_n     = rd_nxt;
            sda_oe_n = ~rd_nxt[7];
            bcnt_n   = '0;
            state_n  = RDATA;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state    <= IDLE;
      bcnt     <= '0;
      sh       <= '0;
      ptr      <= '0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_n;
      bcnt     <= bcnt_n;
      sh       <= sh_n;
      ptr      <= ptr_n;
      rw       <= rw_n;
      sda_oe   <= sda_oe_n;
      busy     <= busy_n;
      wr_valid <= wr_valid_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else if (reg_we) begin
      regs[ptr] <= byte_in;
    end
  end
endmodule
